// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port main-memory arbiter: FSM state encoding,
// port indices and default memory geometry (1024 x 16).
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 16;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t SETUP  = 3'd1;
  localparam state_t WPULSE = 3'd2;
  localparam state_t WHOLD  = 3'd3;
  localparam state_t ACK    = 3'd4;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LS    = 1'b1;

  // Cycles from grant edge to ack cycle for each operation type.
  function automatic int op_latency(input logic is_write);
    return is_write ? 4 : 2;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the port that was not granted last.
// Purely combinational, no latency; a grant is only consumed by the caller when it is idle.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      grant = (last == PORT_FETCH) ? PORT_LS : PORT_FETCH;
    end else begin
      grant = req1 ? PORT_LS : PORT_FETCH;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port memory between fetch (port 0) and load/store (port 1), round-robin on ties.
// Read ack 2 cycles after the grant edge, write ack 4; requesters hold req until ack, inputs sampled only in IDLE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state;
  state_t state_nxt;

  logic last;
  logic grant;
  logic grant_vld;
  logic op_we;
  logic op_port;

  logic ack0_nxt;
  logic ack1_nxt;
  logic busy_nxt;
  logic mem_we_nxt;
  logic take_grant;
  logic capture_rd;

  mem_arb_rr u_rr (
    .req0  (req0),
    .req1  (req1),
    .last  (last),
    .grant (grant),
    .valid (grant_vld)
  );

  assign take_grant = (state == IDLE) && grant_vld;
  assign capture_rd = (state == SETUP) && !op_we;

  // State register plus the registered control outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      busy   <= 1'b0;
      mem_we <= 1'b0;
    end else begin
      state  <= state_nxt;
      ack0   <= ack0_nxt;
      ack1   <= ack1_nxt;
      busy   <= busy_nxt;
      mem_we <= mem_we_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = SETUP;
      SETUP:   state_nxt = op_we ? WPULSE : ACK;
      WPULSE:  state_nxt = WHOLD;
      WHOLD:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // op_port is stale while IDLE, but ACK is never the next state of IDLE.
  always_comb begin
    ack0_nxt   = (state_nxt == ACK) && (op_port == PORT_FETCH);
    ack1_nxt   = (state_nxt == ACK) && (op_port == PORT_LS);
    busy_nxt   = (state_nxt != IDLE);
    mem_we_nxt = (state_nxt == WPULSE);
  end

  // Address/data/op latch only on an IDLE grant, so they stay put through WE and the hold cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last      <= PORT_LS;
      op_we     <= 1'b0;
      op_port   <= PORT_FETCH;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (take_grant) begin
      last    <= grant;
      op_port <= grant;
      if (grant == PORT_LS) begin
        op_we     <= we1;
        mem_addr  <= addr1;
        mem_wdata <= wdata1;
      end else begin
        op_we     <= we0;
        mem_addr  <= addr0;
        mem_wdata <= wdata0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (capture_rd) begin
      if (op_port == PORT_LS) begin
        rdata1 <= mem_rdata;
      end else begin
        rdata0 <= mem_rdata;
      end
    end
  end

  a_one_ack : assert property (@(posedge clk) disable iff (reset) !(ack0 && ack1));
  a_ack_in_ack_state : assert property (@(posedge clk) disable iff (reset)
    (ack0 || ack1) |-> (state == ACK));
  a_we_in_pulse : assert property (@(posedge clk) disable iff (reset)
    mem_we |-> (state == WPULSE));
  a_addr_hold : assert property (@(posedge clk) disable iff (reset)
    (state != IDLE) |=> ($stable(mem_addr) && $stable(mem_wdata)));

endmodule
